// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - icache, hazard, redirect and IF/ID signals of the fetch stage
interface fetch_stage_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instru;
  logic [31:0] nPC;
  logic        fvalid;
  logic        flush;

  modport master (
    output iREN, iaddr, instru, nPC, fvalid, flush,
    input  ihit, iload, stall, redirect, redirect_pc
  );

  modport slave (
    input  iREN, iaddr, instru, nPC, fvalid, flush,
    output ihit, iload, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, icache reads, IF/ID register, redirect and halt
module fetch_stage #(
  parameter logic [31:0] PC_INIT     = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic          CLK,
  input  logic          nRST,
  fetch_stage_if.master fif
);

  typedef enum logic [1:0] {FETCH, DROP, HALTED} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] target, target_n;
  logic [31:0] instru_r, instru_n;
  logic [31:0] npc_r, npc_n;
  logic        fvalid_r, fvalid_n;

  logic [31:0] rpc;
  logic [31:0] pc_inc;

  assign rpc    = fif.redirect_pc & ~32'd3;
  assign pc_inc = pc + 32'd4;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= FETCH;
      pc       <= PC_INIT & ~32'd3;
      target   <= '0;
      instru_r <= '0;
      npc_r    <= '0;
      fvalid_r <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      target   <= target_n;
      instru_r <= instru_n;
      npc_r    <= npc_n;
      fvalid_r <= fvalid_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    target_n = target;
    instru_n = instru_r;
    npc_n    = npc_r;
    fvalid_n = fvalid_r;
    case (state)
      FETCH: begin
        if (fif.redirect) begin
          fvalid_n = 1'b0;
          if (fif.ihit) begin
            pc_n = rpc;
          end else begin
            // icache is still working on pc; park the target until it answers
            target_n = rpc;
            state_n  = DROP;
          end
        end else if (!fif.stall) begin
          if (fif.ihit) begin
            instru_n = fif.iload;
            npc_n    = pc_inc;
            fvalid_n = 1'b1;
            pc_n     = pc_inc;
            if (fif.iload[31:26] == HALT_OPCODE) begin
              state_n = HALTED;
            end
          end else begin
            fvalid_n = 1'b0;
          end
        end
      end
      DROP: begin
        fvalid_n = 1'b0;
        if (fif.redirect) begin
          target_n = rpc;
        end
        if (fif.ihit) begin
          pc_n    = fif.redirect ? rpc : target;
          state_n = FETCH;
        end
      end
      HALTED: begin
        if (fif.redirect) begin
          pc_n     = rpc;
          fvalid_n = 1'b0;
          state_n  = FETCH;
        end else if (!fif.stall) begin
          fvalid_n = 1'b0;
        end
      end
      default: begin
        state_n = FETCH;
      end
    endcase
  end

  // in DROP pc still holds the in-flight address, so iaddr is pc in every state
  assign fif.iREN   = (state != HALTED);
  assign fif.iaddr  = pc;
  assign fif.flush  = fif.redirect;
  assign fif.instru = instru_r;
  assign fif.nPC    = npc_r;
  assign fif.fvalid = fvalid_r;

endmodule
